// File: rtl/trig_pkg.sv
// Shared triggerer definitions: command opcodes, argument lengths
// and the command decoder state encoding.
package trig_pkg;

  localparam logic [7:0] OP_SET_DELAY = 8'h01;
  localparam logic [7:0] OP_SET_WIDTH = 8'h02;
  localparam logic [7:0] OP_SET_COUNT = 8'h03;
  localparam logic [7:0] OP_ARM       = 8'h10;
  localparam logic [7:0] OP_DISARM    = 8'h11;

  typedef enum logic {
    IDLE,
    ARG
  } decState_t;

  function automatic logic isOpcode(input logic [7:0] op);
    logic hit;
    hit = 1'b0;
    case (op)
      OP_SET_DELAY,
      OP_SET_WIDTH,
      OP_SET_COUNT,
      OP_ARM,
      OP_DISARM: hit = 1'b1;
      default:   hit = 1'b0;
    endcase
    return hit;
  endfunction

  function automatic logic [2:0] argLen(input logic [7:0] op);
    logic [2:0] n;
    n = 3'd0;
    case (op)
      OP_SET_DELAY: n = 3'd4;
      OP_SET_WIDTH: n = 3'd4;
      OP_SET_COUNT: n = 3'd1;
      default:      n = 3'd0;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/timeout_counter.sv
// Inter-byte timeout: counts while en, clr restarts it, tc pulses
// on the cycle the count reaches TIMEOUT_CYCLES (clr suppresses tc).
module timeout_counter #(
  parameter int unsigned TIMEOUT_CYCLES = 23400
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic tc
);

  localparam int W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [W-1:0] LAST = W'(TIMEOUT_CYCLES - 1);
  localparam logic [W-1:0] ONE = W'(1);

  logic [W-1:0] cnt;

  assign tc = en & ~clr & (cnt == LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr || !en || tc) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + ONE;
    end
  end

endmodule

// File: rtl/uart_cmd_decoder.sv
// UART byte-stream command decoder: frames opcode + LE argument,
// drives trigger config registers and arm/disarm/error strobes.
module uart_cmd_decoder
  import trig_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 23400,
  parameter logic [7:0]  RESET_COUNT    = 8'd1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        byte_ready,
  input  logic [7:0]  rx_byte,
  output logic [31:0] delay_cycles,
  output logic [31:0] width_cycles,
  output logic [7:0]  pulse_count,
  output logic        cfg_update,
  output logic        arm,
  output logic        disarm,
  output logic        cmd_err,
  output logic        busy
);

  decState_t   state, stateNext;
  logic        byteReadyQ;
  logic        strobe;
  logic        tmoTc;
  logic [2:0]  remain, remainNext;
  logic [7:0]  opReg, opNext;
  logic [31:0] asmReg, asmNext, shifted;
  logic [31:0] delayNext, widthNext;
  logic [7:0]  countNext;
  logic        cfgNext, armNext, disarmNext;
  logic        errNext, busyNext;

  assign strobe  = byte_ready & ~byteReadyQ;
  assign shifted = {rx_byte, asmReg[31:8]};

  timeout_counter #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) uTmo (
    .clk  (clk),
    .rst_n(rst_n),
    .clr  (strobe),
    .en   (state == ARG),
    .tc   (tmoTc)
  );

  always_comb begin
    stateNext  = state;
    remainNext = remain;
    opNext     = opReg;
    asmNext    = asmReg;
    delayNext  = delay_cycles;
    widthNext  = width_cycles;
    countNext  = pulse_count;
    cfgNext    = 1'b0;
    armNext    = 1'b0;
    disarmNext = 1'b0;
    errNext    = 1'b0;
    unique case (1'b1)
      (state == IDLE && strobe): begin
        if (!isOpcode(rx_byte)) begin
          errNext = 1'b1;
        end else if (rx_byte == OP_ARM) begin
          armNext = 1'b1;
        end else if (rx_byte == OP_DISARM) begin
          disarmNext = 1'b1;
        end else begin
          stateNext  = ARG;
          remainNext = argLen(rx_byte);
          opNext     = rx_byte;
          asmNext    = '0;
        end
      end
      (state == ARG && strobe): begin
        asmNext    = shifted;
        remainNext = remain - 3'd1;
        if (remain == 3'd1) begin
          stateNext = IDLE;
          cfgNext   = 1'b1;
          asmNext   = '0;
          case (opReg)
            OP_SET_DELAY: delayNext = shifted;
            OP_SET_WIDTH: widthNext = shifted;
            default:      countNext = rx_byte;
          endcase
        end
      end
      tmoTc: begin
        stateNext  = IDLE;
        remainNext = 3'd0;
        asmNext    = '0;
        errNext    = 1'b1;
      end
      default: begin
      end
    endcase
    busyNext = (stateNext == ARG);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      byteReadyQ   <= 1'b0;
      remain       <= 3'd0;
      opReg        <= 8'd0;
      asmReg       <= '0;
      delay_cycles <= '0;
      width_cycles <= '0;
      pulse_count  <= RESET_COUNT;
      cfg_update   <= 1'b0;
      arm          <= 1'b0;
      disarm       <= 1'b0;
      cmd_err      <= 1'b0;
      busy         <= 1'b0;
    end else begin
      state        <= stateNext;
      byteReadyQ   <= byte_ready;
      remain       <= remainNext;
      opReg        <= opNext;
      asmReg       <= asmNext;
      delay_cycles <= delayNext;
      width_cycles <= widthNext;
      pulse_count  <= countNext;
      cfg_update   <= cfgNext;
      arm          <= armNext;
      disarm       <= disarmNext;
      cmd_err      <= errNext;
      busy         <= busyNext;
    end
  end

endmodule

// File: tb/tb_uart_cmd_decoder.sv
// Self-checking bench for uart_cmd_decoder: table of frames plus
// hand sequences for latency, timeout, held strobe and reset abort.
module tb_uart_cmd_decoder;

  localparam int T = 23400;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        byte_ready;
  logic [7:0]  rx_byte;
  logic [31:0] delay_cycles;
  logic [31:0] width_cycles;
  logic [7:0]  pulse_count;
  logic        cfg_update;
  logic        arm;
  logic        disarm;
  logic        cmd_err;
  logic        busy;

  int nChecks = 0;
  int nFail = 0;
  int cfgCnt = 0;
  int armCnt = 0;
  int disCnt = 0;
  int errCnt = 0;

  uart_cmd_decoder #(
    .TIMEOUT_CYCLES(T),
    .RESET_COUNT   (8'd1)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .byte_ready  (byte_ready),
    .rx_byte     (rx_byte),
    .delay_cycles(delay_cycles),
    .width_cycles(width_cycles),
    .pulse_count (pulse_count),
    .cfg_update  (cfg_update),
    .arm         (arm),
    .disarm      (disarm),
    .cmd_err     (cmd_err),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (cfg_update) cfgCnt++;
    if (arm)        armCnt++;
    if (disarm)     disCnt++;
    if (cmd_err)    errCnt++;
  end

  typedef struct {
    logic [39:0] bytes;
    int          n;
    logic [31:0] dly;
    logic [31:0] wid;
    logic [7:0]  cnt;
    int          cfg;
    int          arm;
    int          dis;
    int          err;
  } vec_t;

  vec_t vecs [10];

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    nChecks++;
    if (act !== exp) begin
      nFail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic sendByte(input logic [7:0] b, input int hold);
    @(negedge clk);
    rx_byte    = b;
    byte_ready = 1'b1;
    repeat (hold) @(negedge clk);
    byte_ready = 1'b0;
  endtask

  task automatic chkIdle(input string name, input logic [31:0] dly,
                         input logic [31:0] wid, input logic [7:0] cnt);
    chk({name, " delay"}, delay_cycles, dly);
    chk({name, " width"}, width_cycles, wid);
    chk({name, " count"}, {24'd0, pulse_count}, {24'd0, cnt});
    chk({name, " busy"}, {31'd0, busy}, 32'd0);
  endtask

  initial begin
    int c0, a0, d0, e0;
    logic [7:0] b;

    vecs[0] = '{40'h0000271001, 5, 32'h2710, 32'h0, 8'h01, 1, 0, 0, 0};
    vecs[1] = '{40'h00000000FF02 , 5, 32'h2710, 32'hFF, 8'h01, 1, 0, 0, 0};
    vecs[2] = '{40'h0000000503, 2, 32'h2710, 32'hFF, 8'h05, 1, 0, 0, 0};
    vecs[3] = '{40'h0000000010, 1, 32'h2710, 32'hFF, 8'h05, 0, 1, 0, 0};
    vecs[4] = '{40'h0000000011, 1, 32'h2710, 32'hFF, 8'h05, 0, 0, 1, 0};
    vecs[5] = '{40'h000000007E, 1, 32'h2710, 32'hFF, 8'h05, 0, 0, 0, 1};
    vecs[6] = '{40'h0000000010, 1, 32'h2710, 32'hFF, 8'h05, 0, 1, 0, 0};
    vecs[7] = '{40'h0000000003, 2, 32'h2710, 32'hFF, 8'h00, 1, 0, 0, 0};
    vecs[8] = '{40'hDEADBEEF01, 5, 32'hDEADBEEF, 32'hFF, 8'h00, 1, 0, 0, 0};
    vecs[9] = '{40'h0000010002, 5, 32'hDEADBEEF, 32'h100, 8'h00, 1, 0, 0, 0};

    rst_n      = 1'b0;
    byte_ready = 1'b0;
    rx_byte    = 8'h00;
    repeat (3) @(negedge clk);
    chkIdle("reset", 32'h0, 32'h0, 8'h01);
    chk("reset strobes", {28'd0, cfg_update, arm, disarm, cmd_err}, 32'd0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    for (int i = 0; i < 10; i++) begin
      c0 = cfgCnt; a0 = armCnt; d0 = disCnt; e0 = errCnt;
      for (int k = 0; k < vecs[i].n; k++) begin
        b = vecs[i].bytes[8*k +: 8];
        sendByte(b, 1);
      end
      repeat (3) @(negedge clk);
      chkIdle($sformatf("vec%0d", i), vecs[i].dly, vecs[i].wid,
              vecs[i].cnt);
      chk($sformatf("vec%0d cfg", i), cfgCnt - c0, vecs[i].cfg);
      chk($sformatf("vec%0d arm", i), armCnt - a0, vecs[i].arm);
      chk($sformatf("vec%0d disarm", i), disCnt - d0, vecs[i].dis);
      chk($sformatf("vec%0d err", i), errCnt - e0, vecs[i].err);
    end

    // arm / disarm one cycle after their strobe edge, one cycle wide
    c0 = cfgCnt;
    sendByte(8'h10, 1);
    chk("arm lat", {31'd0, arm}, 32'd1);
    chk("arm lat disarm", {31'd0, disarm}, 32'd0);
    @(negedge clk);
    chk("arm width", {31'd0, arm}, 32'd0);
    sendByte(8'h11, 1);
    chk("disarm lat", {31'd0, disarm}, 32'd1);
    chk("disarm lat arm", {31'd0, arm}, 32'd0);
    @(negedge clk);
    chk("disarm width", {31'd0, disarm}, 32'd0);
    chk("arm seq cfg", cfgCnt - c0, 0);

    // busy with opcode, timeout exactly T cycles after last byte
    e0 = errCnt;
    sendByte(8'h01, 1);
    chk("busy rise", {31'd0, busy}, 32'd1);
    sendByte(8'hAA, 1);
    repeat (T - 1) @(negedge clk);
    chk("tmo early err", {31'd0, cmd_err}, 32'd0);
    chk("tmo early busy", {31'd0, busy}, 32'd1);
    @(negedge clk);
    chk("tmo err", {31'd0, cmd_err}, 32'd1);
    chk("tmo busy", {31'd0, busy}, 32'd0);
    @(negedge clk);
    chk("tmo err width", {31'd0, cmd_err}, 32'd0);
    chk("tmo err count", errCnt - e0, 1);
    chk("tmo delay", delay_cycles, 32'hDEADBEEF);

    // opcode held high 5 cycles counts once
    c0 = cfgCnt; e0 = errCnt;
    sendByte(8'h01, 5);
    sendByte(8'hAA, 1);
    sendByte(8'hBB, 1);
    sendByte(8'hCC, 1);
    chk("hold busy", {31'd0, busy}, 32'd1);
    sendByte(8'hDD, 1);
    chk("hold cfg lat", {31'd0, cfg_update}, 32'd1);
    chk("hold busy fall", {31'd0, busy}, 32'd0);
    repeat (2) @(negedge clk);
    chk("hold delay", delay_cycles, 32'hDDCCBBAA);
    chk("hold cfg", cfgCnt - c0, 1);
    chk("hold err", errCnt - e0, 0);

    // byte arriving on the expiry cycle wins
    c0 = cfgCnt; e0 = errCnt;
    sendByte(8'h02, 1);
    sendByte(8'h11, 1);
    repeat (T - 2) @(negedge clk);
    sendByte(8'h22, 1);
    chk("race err", {31'd0, cmd_err}, 32'd0);
    chk("race busy", {31'd0, busy}, 32'd1);
    sendByte(8'h33, 1);
    sendByte(8'h44, 1);
    repeat (2) @(negedge clk);
    chk("race width", width_cycles, 32'h44332211);
    chk("race err count", errCnt - e0, 0);
    chk("race cfg", cfgCnt - c0, 1);

    // reset mid-frame aborts silently
    e0 = errCnt;
    sendByte(8'h02, 1);
    sendByte(8'h11, 1);
    sendByte(8'h22, 1);
    #2 rst_n = 1'b0;
    #1;
    chkIdle("arst", 32'h0, 32'h0, 8'h01);
    chk("arst strobes", {28'd0, cfg_update, arm, disarm, cmd_err}, 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    sendByte(8'h03, 1);
    sendByte(8'h09, 1);
    repeat (2) @(negedge clk);
    chkIdle("post rst", 32'h0, 32'h0, 8'h09);
    chk("post rst err", errCnt - e0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             nChecks, nFail);
    $finish;
  end

endmodule
